// File: rtl/mem2_load_stage.sv
// mem2_load_stage
//
// Second memory pipeline stage. It sits directly after MEM and does three jobs:
//   - latches the instruction leaving MEM and presents it to the WB register;
//   - waits for the D-cache read response of an issued load, then aligns and
//     sign/zero-extends the word (LWL/LWR partial merges are optional);
//   - stalls the pipeline while a response is outstanding, and drains the
//     response of a flushed load so that it cannot be mistaken for a later one.
//
// Optional feature (compile-time macro):
//   MEM2_LWLR_EN - when defined, LWL/LWR merge the returned word with the old rt
//                  value. When undefined, types 6/7 behave like LW and rt is not
//                  stored.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   mem2_flush         kill the stage content (wins over mem2_wr)
//   mem2_wr            stage write enable from the hazard unit
//   mem_valid .. mem_rt_val   instruction fields leaving MEM
//   dcache_rvalid/rdata       D-cache read response (one pulse per issued load)
//   mem2_stall         stage cannot accept a new instruction
//   wb_valid, wb_pc, wb_dst, wb_reg_wr, wb_data   write-back view of the entry

module mem2_load_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem2_flush,
  input  logic        mem2_wr,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic [2:0]  mem_ld_type,
  input  logic        mem_ld_issued,
  input  logic [1:0]  mem_addr_lo,
  input  logic [4:0]  mem_dst,
  input  logic        mem_reg_wr,
  input  logic [31:0] mem_result,
  input  logic [31:0] mem_rt_val,
  input  logic        dcache_rvalid,
  input  logic [31:0] dcache_rdata,
  output logic        mem2_stall,
  output logic        wb_valid,
  output logic [31:0] wb_pc,
  output logic [4:0]  wb_dst,
  output logic        wb_reg_wr,
  output logic [31:0] wb_data
);

  typedef enum logic [1:0] {StPass, StWait, StReady, StDrain} state_e;

  state_e      state_q;
  logic        valid_q;
  logic        reg_wr_q;
  logic [31:0] pc_q;
  logic [4:0]  dst_q;
  logic [2:0]  ld_type_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] result_q;
  logic [31:0] buf_q;

`ifdef MEM2_LWLR_EN
  logic [31:0] rt_q;
`else
  logic        unused_rt;
  assign unused_rt = ^mem_rt_val;
`endif

  logic        waiting;
  logic        latch;
  logic        start_wait;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] aligned;

  assign waiting    = (state_q == StWait);
  assign mem2_stall = (state_q == StDrain) || (waiting && !dcache_rvalid);
  assign latch      = mem2_wr && !mem2_flush && !mem2_stall;
  assign start_wait = mem_valid && mem_ld_issued && (mem_ld_type != 3'd0);

  // valid_q is always clear in StDrain, so masking with the stall also hides
  // the entry while a WAIT has not yet seen its response.
  assign wb_valid  = valid_q && !mem2_stall;
  assign wb_reg_wr = reg_wr_q && wb_valid;
  assign wb_pc     = pc_q;
  assign wb_dst    = dst_q;

  // Load alignment of the incoming response word.
  always_comb begin
    ld_byte = 8'h00;
    unique case (addr_lo_q)
      2'd0: ld_byte = dcache_rdata[7:0];
      2'd1: ld_byte = dcache_rdata[15:8];
      2'd2: ld_byte = dcache_rdata[23:16];
      2'd3: ld_byte = dcache_rdata[31:24];
      default: ld_byte = 8'h00;
    endcase
    // addr_lo[0] is ignored for halfwords; misalignment traps upstream.
    ld_half = addr_lo_q[1] ? dcache_rdata[31:16] : dcache_rdata[15:0];

    aligned = dcache_rdata;
    case (ld_type_q)
      3'd1: aligned = {{24{ld_byte[7]}}, ld_byte};
      3'd2: aligned = {24'h000000, ld_byte};
      3'd3: aligned = {{16{ld_half[15]}}, ld_half};
      3'd4: aligned = {16'h0000, ld_half};
`ifdef MEM2_LWLR_EN
      3'd6: begin
        unique case (addr_lo_q)
          2'd0: aligned = {dcache_rdata[7:0], rt_q[23:0]};
          2'd1: aligned = {dcache_rdata[15:0], rt_q[15:0]};
          2'd2: aligned = {dcache_rdata[23:0], rt_q[7:0]};
          2'd3: aligned = dcache_rdata;
          default: aligned = dcache_rdata;
        endcase
      end
      3'd7: begin
        unique case (addr_lo_q)
          2'd0: aligned = dcache_rdata;
          2'd1: aligned = {rt_q[31:24], dcache_rdata[31:8]};
          2'd2: aligned = {rt_q[31:16], dcache_rdata[31:16]};
          2'd3: aligned = {rt_q[31:8], dcache_rdata[31:24]};
          default: aligned = dcache_rdata;
        endcase
      end
`endif
      default: aligned = dcache_rdata;
    endcase
  end

  always_comb begin
    wb_data = result_q;
    case (state_q)
      StWait:  wb_data = aligned;
      StReady: wb_data = buf_q;
      default: wb_data = result_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StPass;
      valid_q   <= 1'b0;
      reg_wr_q  <= 1'b0;
      pc_q      <= 32'h0;
      dst_q     <= 5'h0;
      ld_type_q <= 3'h0;
      addr_lo_q <= 2'h0;
      result_q  <= 32'h0;
      buf_q     <= 32'h0;
`ifdef MEM2_LWLR_EN
      rt_q      <= 32'h0;
`endif
    end else begin
      if (mem2_flush) begin
        valid_q <= 1'b0;
        // A response still owed to a killed load must be swallowed in DRAIN.
        if ((waiting || state_q == StDrain) && !dcache_rvalid) begin
          state_q <= StDrain;
        end else begin
          state_q <= StPass;
        end
      end else if (latch) begin
        valid_q   <= mem_valid;
        reg_wr_q  <= mem_reg_wr;
        pc_q      <= mem_pc;
        dst_q     <= mem_dst;
        ld_type_q <= mem_ld_type;
        addr_lo_q <= mem_addr_lo;
        result_q  <= mem_result;
`ifdef MEM2_LWLR_EN
        rt_q      <= mem_rt_val;
`endif
        state_q   <= start_wait ? StWait : StPass;
      end else begin
        case (state_q)
          StWait:  if (dcache_rvalid) state_q <= StReady;
          StDrain: if (dcache_rvalid) state_q <= StPass;
          default: ;
        endcase
      end

      if (waiting && dcache_rvalid) begin
        buf_q <= aligned;
      end
    end
  end

endmodule

// File: tb/tb_mem2_load_stage.sv
module tb_mem2_load_stage;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem2_flush = 1'b0;
  logic        mem2_wr = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_pc = '0;
  logic [2:0]  mem_ld_type = '0;
  logic        mem_ld_issued = 1'b0;
  logic [1:0]  mem_addr_lo = '0;
  logic [4:0]  mem_dst = '0;
  logic        mem_reg_wr = 1'b0;
  logic [31:0] mem_result = '0;
  logic [31:0] mem_rt_val = '0;
  logic        dcache_rvalid = 1'b0;
  logic [31:0] dcache_rdata = '0;
  logic        mem2_stall;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [4:0]  wb_dst;
  logic        wb_reg_wr;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  mem2_load_stage dut (
    .clk(clk), .resetn(resetn), .mem2_flush(mem2_flush), .mem2_wr(mem2_wr),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_ld_type(mem_ld_type),
    .mem_ld_issued(mem_ld_issued), .mem_addr_lo(mem_addr_lo), .mem_dst(mem_dst),
    .mem_reg_wr(mem_reg_wr), .mem_result(mem_result), .mem_rt_val(mem_rt_val),
    .dcache_rvalid(dcache_rvalid), .dcache_rdata(dcache_rdata),
    .mem2_stall(mem2_stall), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_dst(wb_dst),
    .wb_reg_wr(wb_reg_wr), .wb_data(wb_data)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: the held entry plus two facts about the cache response,
  // "entry still owes a response" and "an orphan response must be discarded".
  logic        m_valid = 0, m_reg_wr = 0, m_wait = 0, m_have = 0, m_discard = 0;
  logic [31:0] m_pc = 0, m_result = 0, m_rt = 0, m_data = 0;
  logic [4:0]  m_dst = 0;
  logic [2:0]  m_type = 0;
  logic [1:0]  m_a = 0;

  // D-cache responder for the random phase.
  logic auto_cache = 0;
  logic c_pending = 0;
  int   c_cnt = 0;

  function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [1:0] a,
                                           input logic [31:0] rd, input logic [31:0] rt);
    logic [31:0] byt, half;
    byt  = (rd >> (8 * a)) & 32'hFF;
    half = (rd >> (16 * a[1])) & 32'hFFFF;
    case (t)
      3'd1: return byt[7] ? (byt | 32'hFFFF_FF00) : byt;
      3'd2: return byt;
      3'd3: return half[15] ? (half | 32'hFFFF_0000) : half;
      3'd4: return half;
`ifdef MEM2_LWLR_EN
      3'd6: return (rd << (8 * (3 - a))) | (rt & ((32'h1 << (8 * (3 - a))) - 32'h1));
      3'd7: return (rd >> (8 * a)) | (rt & ~(32'hFFFF_FFFF >> (8 * a)));
`endif
      default: return rd;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic e_stall, e_valid;
    logic [31:0] e_data;
    e_stall = m_discard || (m_wait && !dcache_rvalid);
    e_valid = m_valid && !e_stall;
    chk("stall", mem2_stall, e_stall);
    chk("wb_valid", wb_valid, e_valid);
    chk("wb_reg_wr", wb_reg_wr, m_reg_wr && e_valid);
    if (e_valid) begin
      e_data = m_wait ? ref_load(m_type, m_a, dcache_rdata, m_rt) : (m_have ? m_data : m_result);
      chk("wb_pc", wb_pc, m_pc);
      chk("wb_dst", wb_dst, m_dst);
      chk("wb_data", wb_data, e_data);
    end
  endtask

  task automatic model_update();
    logic st, lat;
    st  = m_discard || (m_wait && !dcache_rvalid);
    lat = mem2_wr && !mem2_flush && !st;
    if (auto_cache) begin
      if (dcache_rvalid) c_pending = 0;
      else if (c_pending) c_cnt--;
    end
    if (mem2_flush) begin
      m_discard = (m_wait || m_discard) && !dcache_rvalid;
      m_wait = 0; m_have = 0; m_valid = 0;
    end else if (lat) begin
      m_valid = mem_valid; m_reg_wr = mem_reg_wr; m_pc = mem_pc; m_dst = mem_dst;
      m_type = mem_ld_type; m_a = mem_addr_lo; m_result = mem_result; m_rt = mem_rt_val;
      m_wait = mem_valid && mem_ld_issued && (mem_ld_type != 3'd0);
      m_have = 0; m_discard = 0;
      if (m_wait && auto_cache) begin
        c_pending = 1;
        c_cnt = int'($urandom_range(0, 3));
      end
    end else begin
      if (m_wait && dcache_rvalid) begin
        m_data = ref_load(m_type, m_a, dcache_rdata, m_rt);
        m_have = 1; m_wait = 0;
      end
      if (m_discard && dcache_rvalid) m_discard = 0;
    end
  endtask

  // Cycle phases: inputs are set at negedge, outputs sampled 2 units later.
  task automatic settle();
    #2;
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    mem2_wr = 0; mem2_flush = 0; mem_valid = 0; mem_ld_type = 0; mem_ld_issued = 0;
    dcache_rvalid = 0; dcache_rdata = 32'h5A5A_5A5A;
  endtask

  task automatic set_mem(input logic v, input logic [31:0] pc, input logic [2:0] t,
                         input logic iss, input logic [1:0] a, input logic [4:0] dst,
                         input logic rw, input logic [31:0] res, input logic [31:0] rt);
    mem_valid = v; mem_pc = pc; mem_ld_type = t; mem_ld_issued = iss; mem_addr_lo = a;
    mem_dst = dst; mem_reg_wr = rw; mem_result = res; mem_rt_val = rt;
  endtask

  task automatic do_reset();
    resetn = 0; mem2_wr = 0; mem2_flush = 0; dcache_rvalid = 0;
    #2;
    chk("rst_stall", mem2_stall, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_reg_wr", wb_reg_wr, 0);
    chk("rst_wb_pc", wb_pc, 0);
    chk("rst_wb_dst", wb_dst, 0);
    chk("rst_wb_data", wb_data, 0);
    m_valid = 0; m_reg_wr = 0; m_wait = 0; m_have = 0; m_discard = 0;
    m_pc = 0; m_result = 0; m_rt = 0; m_data = 0; m_dst = 0; m_type = 0; m_a = 0;
    c_pending = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    resetn = 1;
  endtask

  initial begin
    @(negedge clk);
    idle();
    do_reset();

    // Non-load result one cycle after latch.
    idle(); set_mem(1, 32'h100, 0, 0, 0, 5'd5, 1, 32'h1234_5678, 0); mem2_wr = 1;
    settle(); adv();
    idle(); settle();
    chk("nl_valid", wb_valid, 1); chk("nl_data", wb_data, 32'h1234_5678);
    chk("nl_stall", mem2_stall, 0);
    adv();

    // LB a=2, response 3 cycles after latch.
    idle(); set_mem(1, 32'h104, 3'd1, 1, 2'd2, 5'd6, 1, 32'hDEAD, 0); mem2_wr = 1;
    settle(); adv();
    idle(); settle(); chk("lb_stall1", mem2_stall, 1); chk("lb_nvalid", wb_valid, 0); adv();
    idle(); settle(); chk("lb_stall2", mem2_stall, 1); adv();
    idle(); dcache_rvalid = 1; dcache_rdata = 32'h0080_FF11; settle();
    chk("lb_stall3", mem2_stall, 0); chk("lb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_valid", wb_valid, 1);
    adv();
    idle(); dcache_rdata = 32'h1234_5678; settle(); chk("lb_hold", wb_data, 32'hFFFF_FF80); adv();

    // LHU a=2, with a back-to-back LW latched in the response cycle.
    idle(); set_mem(1, 32'h108, 3'd4, 1, 2'd2, 5'd7, 1, 0, 0); mem2_wr = 1;
    settle(); adv();
    idle(); dcache_rvalid = 1; dcache_rdata = 32'hBEEF_0000;
    set_mem(1, 32'h10C, 3'd5, 1, 2'd0, 5'd8, 1, 0, 0); mem2_wr = 1;
    settle(); chk("lhu_data", wb_data, 32'h0000_BEEF); chk("lhu_stall", mem2_stall, 0);
    adv();
    idle(); dcache_rvalid = 1; dcache_rdata = 32'hCAFE_F00D; settle();
    chk("lw_data", wb_data, 32'hCAFE_F00D); chk("lw_pc", wb_pc, 32'h10C);
    adv();
    idle(); settle(); adv();

    // LWL a=1.
    idle(); set_mem(1, 32'h110, 3'd6, 1, 2'd1, 5'd9, 1, 0, 32'hAABB_CCDD); mem2_wr = 1;
    settle(); adv();
    idle(); dcache_rvalid = 1; dcache_rdata = 32'h1122_3344; settle();
`ifdef MEM2_LWLR_EN
    chk("lwl_data", wb_data, 32'h3344_CCDD);
`else
    chk("lwl_data", wb_data, 32'h1122_3344);
`endif
    adv();

    // Flush while waiting: drain the orphan response, block latches until then.
    idle(); set_mem(1, 32'h114, 3'd5, 1, 2'd0, 5'd10, 1, 0, 0); mem2_wr = 1;
    settle(); adv();
    idle(); set_mem(1, 32'h118, 3'd0, 0, 2'd0, 5'd11, 1, 32'h77, 0);
    mem2_flush = 1; mem2_wr = 1;
    settle(); adv();
    mem2_flush = 0; mem2_wr = 1; settle();
    chk("dr_stall", mem2_stall, 1); chk("dr_valid", wb_valid, 0);
    adv();
    dcache_rvalid = 1; dcache_rdata = 32'hFFFF_FFFF; settle();
    chk("dr_stall_rv", mem2_stall, 1); chk("dr_valid_rv", wb_valid, 0);
    adv();
    dcache_rvalid = 0; settle();
    chk("dr_pass_stall", mem2_stall, 0); chk("dr_pass_valid", wb_valid, 0);
    adv();
    idle(); settle();
    chk("dr_new_valid", wb_valid, 1); chk("dr_new_pc", wb_pc, 32'h118);
    chk("dr_new_data", wb_data, 32'h77);
    adv();

    // Load not issued behaves like a non-load.
    idle(); set_mem(1, 32'h11C, 3'd5, 0, 2'd0, 5'd12, 1, 32'h0BAD_F00D, 0); mem2_wr = 1;
    settle(); adv();
    idle(); settle();
    chk("ni_stall", mem2_stall, 0); chk("ni_valid", wb_valid, 1);
    chk("ni_data", wb_data, 32'h0BAD_F00D);
    adv();

    // Reset in the middle of a WAIT.
    idle(); set_mem(1, 32'h120, 3'd5, 1, 2'd0, 5'd13, 1, 0, 0); mem2_wr = 1;
    settle(); adv();
    idle(); settle(); chk("rw_stall", mem2_stall, 1);
    do_reset();
    idle(); settle(); chk("rw_after", mem2_stall, 0); adv();

    // Randomized traffic with an in-bench D-cache responder.
    auto_cache = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        dcache_rvalid = c_pending && (c_cnt == 0);
        dcache_rdata  = $urandom;
        mem2_wr       = ($urandom_range(0, 9) < 7);
        mem2_flush    = ($urandom_range(0, 14) == 0);
        if (m_discard && dcache_rvalid) mem2_flush = 0;
        set_mem($urandom_range(0, 9) != 0, $urandom, 3'($urandom_range(0, 7)),
                $urandom_range(0, 4) != 0, 2'($urandom), 5'($urandom),
                1'($urandom), $urandom, $urandom);
        settle();
        adv();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem2_load_stage.md
# mem2_load_stage

Second memory pipeline stage, directly downstream of the MEM stage. It latches the instruction leaving MEM and waits for the data-cache read response of any load issued there. It aligns and sign/zero-extends the returned word, including partial-word merges, and presents the write-back result to the WB register. It also generates the pipeline stall while a load response is outstanding, and discards responses that belong to flushed loads.

## Interface
Parameters:
- none (the LWL/LWR feature is macro-controlled, see Configuration)

Ports:
- `clk`  in  1  — pipeline clock; single clock domain.
- `resetn`  in  1  — asynchronous, active-low reset.
- `mem2_flush`  in  1  — kill the stage content; has priority over `mem2_wr`.
- `mem2_wr`  in  1  — stage write enable from the hazard unit; latches the MEM outputs.
- `mem_valid`  in  1  — MEM holds a real instruction (not a bubble).
- `mem_pc`  in  32  — PC of the MEM instruction.
- `mem_ld_type`  in  3  — load type: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR.
- `mem_ld_issued`  in  1  — the load was actually sent to the D-cache (`valid`=1, no exception).
- `mem_addr_lo`  in  2  — virtual address bits [1:0].
- `mem_dst`  in  5  — destination GPR.
- `mem_reg_wr`  in  1  — GPR write enable, already gated for exceptions and DisWr.
- `mem_result`  in  32  — non-load result.
- `mem_rt_val`  in  32  — old rt value, used for LWL/LWR merging.
- `dcache_rvalid`  in  1  — D-cache read data valid; exactly one pulse per issued load.
- `dcache_rdata`  in  32  — D-cache read word.
- `mem2_stall`  out  1  — stage cannot accept a new instruction.
- `wb_valid`  out  1  — the stage holds a completed instruction.
- `wb_pc`  out  32  — PC of the held instruction.
- `wb_dst`  out  5  — destination GPR of the held instruction.
- `wb_reg_wr`  out  1  — GPR write enable; equals the latched `mem_reg_wr` & `wb_valid`.
- `wb_data`  out  32  — write-back value.

## Operation
- **State machine:** PASS, WAIT, READY, DRAIN. Reset state is PASS with the entry invalid.
- **Latch:** when `mem2_wr` & !`mem2_flush` & !`mem2_stall`, the stage captures pc, dst, reg_wr, ld_type, addr_lo, rt_val, result and valid=`mem_valid`.
  - Next state is WAIT if `mem_valid` & `mem_ld_issued` & `mem_ld_type`!=0.
  - Otherwise next state is PASS.
- **WAIT:**
  - `mem2_stall` = !`dcache_rvalid`.
  - When `dcache_rvalid`=1, the aligned result is driven combinationally onto `wb_data`, captured into the data buffer, and the state moves to READY.
  - If `mem2_wr` is asserted in the same cycle, a new instruction is latched instead, and the next state follows the latch rule.
- **READY:** `wb_data` comes from the buffer. Stall=0. The latch rule applies.
- **PASS:** `wb_data`=`mem_result` for valid non-load entries, and for loads not issued (ld_type gated off).
- **Flush:**
  - In WAIT with no `dcache_rvalid` that cycle: go to DRAIN.
  - In DRAIN: stay in DRAIN.
  - Otherwise: go to PASS.
  - The entry is always invalidated.
- **DRAIN:** `mem2_stall`=1, `wb_valid`=0. The next `dcache_rvalid` pulse is discarded, then the state returns to PASS. New latches are blocked until then.
- **Alignment (a = addr_lo):**
  - LB/LBU: byte `rdata[8a+7:8a]`, sign- or zero-extended.
  - LH/LHU: halfword `rdata[16a[1]+15:16a[1]]`, sign- or zero-extended. a[0] is ignored (alignment exceptions are raised upstream).
  - LW: `rdata`.
- **LWL (little-endian):**
  - a=0: {rdata[7:0], rt[23:0]}
  - a=1: {rdata[15:0], rt[15:0]}
  - a=2: {rdata[23:0], rt[7:0]}
  - a=3: rdata
- **LWR:**
  - a=0: rdata
  - a=1: {rt[31:24], rdata[31:8]}
  - a=2: {rt[31:16], rdata[31:16]}
  - a=3: {rt[31:8], rdata[31:24]}

## Timing
- **Reset values:** `mem2_stall`=0, `wb_valid`=0, `wb_reg_wr`=0, `wb_pc`=0, `wb_dst`=0, `wb_data`=0. The data buffer is 0.
- **Non-load latency:** result visible on `wb_*` in the cycle after the latch.
- **Load latency:** `wb_data` becomes valid combinationally in the cycle `dcache_rvalid`=1. The earliest is 1 cycle after the latch (D-cache hit). It is held stable from the buffer afterwards.
- **`wb_valid`** is 0 while in WAIT without `dcache_rvalid`, so WB never sees partial results.
- **`dcache_rvalid` in PASS or READY** is a protocol violation; it is ignored.
- **Flush and `dcache_rvalid` in the same WAIT cycle:** the response is consumed and the state goes to PASS, not DRAIN.
- **Reset mid-WAIT or mid-DRAIN:** the stage returns to PASS immediately. The D-cache is reset in the same domain, so no orphan response remains.

## Configuration
- **`MEM2_LWLR_EN` defined:** LWL/LWR merge as specified, using `mem_rt_val`.
- **`MEM2_LWLR_EN` undefined:**
  - Types 6/7 are treated as LW (`wb_data`=`dcache_rdata`).
  - `mem_rt_val` is unused, and the rt register is not synthesized.

## Test plan
- **Reset then non-load:** `mem_result`=0x1234_5678, mem_reg_wr=1 latched → next cycle `wb_valid`=1, `wb_data`=0x1234_5678, `mem2_stall`=0.
- **LB sign-extension:** a=2, rvalid 3 cycles after latch with rdata=0x0080_FF11 → stall=1 for 2 cycles; `wb_data`=0xFFFF_FF80 in the rvalid cycle and held afterwards.
- **LHU:** a=2, rdata=0xBEEF_0000 → 0x0000_BEEF. LW with back-to-back `mem2_wr` in the rvalid cycle → both results correct in consecutive cycles.
- **LWL with `MEM2_LWLR_EN` defined:** a=1, rt=0xAABB_CCDD, rdata=0x1122_3344 → 0x3344_CCDD. Without the macro → 0x1122_3344.
- **Flush in WAIT:** no rvalid, flush → DRAIN; stall=1 and wb_valid=0 until rvalid (rdata ignored); new latch occurs only afterwards.
- **Unissued load and reset mid-WAIT:** load with `mem_ld_issued`=0 (exception) → no stall, `wb_data`=`mem_result`. `resetn` low during WAIT → all outputs 0, state PASS.
